// File: rtl/audio_uart_rx.sv
// Generic show-ahead FIFO with pointer-wrap full/empty detection.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: wr_rdy drops when full unless the head is popped in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         do_wr;
    logic         do_rd;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = !empty;
    assign do_rd  = rd_vld && rd_rdy;
    // A pop frees the head slot this cycle, so a full FIFO can still take a write.
    assign wr_rdy = !full || do_rd;
    assign do_wr  = wr_vld && wr_rdy;
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

// 8N1 UART receiver with mid-bit sampling feeding a small show-ahead byte FIFO.
// Latency: byte at FIFO head one cycle after the stop-bit sample.
// Backpressure: o_valid/i_ready; bytes arriving at a full FIFO are dropped (sticky o_overflow).
module audio_uart_rx #(
    parameter int p_clksPerBit = 52,
    parameter int p_fifoDepth  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_serial,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frameErr,
    output logic       o_overflow
);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    localparam logic [8:0] HALF_LAST = 9'(p_clksPerBit / 2 - 1);
    localparam logic [8:0] BIT_LAST  = 9'(p_clksPerBit - 1);

    logic       rx_meta;
    logic       s_rx;
    state_t     state;
    state_t     state_n;
    logic [8:0] cnt;
    logic [8:0] cnt_n;
    logic [2:0] idx;
    logic [2:0] idx_n;
    logic [7:0] sh;
    logic [7:0] sh_n;
    logic       push;
    logic       frame_err_n;
    logic       wr_rdy;
    logic       frame_err;
    logic       overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            s_rx    <= 1'b1;
        end else begin
            rx_meta <= i_serial;
            s_rx    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sh        <= sh_n;
            frame_err <= frame_err_n;
            overflow  <= overflow | (push && !wr_rdy);
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        sh_n        = sh;
        push        = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            IDLE: begin
                if (!s_rx) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (s_rx) begin
                        state_n = IDLE;
                    end else begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = DATA;
                    end
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    sh_n  = {s_rx, sh[7:1]};
                    cnt_n = '0;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    // Returning to IDLE mid-stop-bit lets the next start edge be caught on time.
                    if (s_rx) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 9'd1;
                end
            end
            BREAK: begin
                if (s_rx) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    fifo #(
        .W     (8),
        .DEPTH (p_fifoDepth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .wr_vld  (push),
        .wr_rdy  (wr_rdy),
        .wr_dat  (sh),
        .rd_vld  (o_valid),
        .rd_rdy  (i_ready),
        .rd_dat  (o_data)
    );

    assign o_frameErr = frame_err;
    assign o_overflow = overflow;
endmodule

// File: tb/tb_audio_uart_rx.sv
// Directed bench for audio_uart_rx at 8 clocks per bit: table of back-to-back bytes
// plus hand sequences for latency, framing error, false start, overflow and reset.
module tb_audio_uart_rx;
    localparam int CPB = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_serial;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frameErr;
    logic       o_overflow;

    audio_uart_rx #(.p_clksPerBit(CPB), .p_fifoDepth(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_serial   (i_serial),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_frameErr (o_frameErr),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int         cyc = 0;
    logic [7:0] rx_q [$];
    int         v_cnt  = 0;
    int         v_rise = 0;
    logic       v_prev = 1'b0;
    int         fe_cnt = 0;
    int         fe_at  = 0;

    always @(posedge i_clk) cyc++;

    always @(negedge i_clk) begin
        if (o_valid && i_ready) rx_q.push_back(o_data);
        if (o_valid) v_cnt++;
        if (o_valid && !v_prev) v_rise = cyc;
        v_prev = o_valid;
        if (o_frameErr) begin
            fe_cnt++;
            fe_at = cyc;
        end
    end

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        i_serial = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            i_serial = b[i];
            idle(CPB);
        end
        i_serial = stop;
        idle(CPB);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [5];
    logic [7:0] exp_drain [5];
    int         base;
    int         vb;
    int         fb;
    int         t0;

    initial begin
        vecs[0] = '{8'h00, 8'h00};
        vecs[1] = '{8'hFF, 8'hFF};
        vecs[2] = '{8'h55, 8'h55};
        vecs[3] = '{8'h0F, 8'h0F};
        vecs[4] = '{8'h80, 8'h80};
        exp_drain[0] = 8'h01;
        exp_drain[1] = 8'h02;
        exp_drain[2] = 8'h03;
        exp_drain[3] = 8'h04;
        exp_drain[4] = 8'h06;

        i_rst_n  = 1'b0;
        i_serial = 1'b1;
        i_ready  = 1'b1;
        idle(3);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_fe", o_frameErr, 0);
        check("rst_ovf", o_overflow, 0);
        i_rst_n = 1'b1;
        idle(4);

        // Single byte with exact latency: stop sample is 78 cycles after the drive edge.
        base = rx_q.size();
        vb   = v_cnt;
        t0   = cyc;
        send_byte(8'hA5, 1'b1);
        idle(8);
        check("a5_count", rx_q.size() - base, 1);
        check("a5_data", rx_q[base], 8'hA5);
        check("a5_valid_cycles", v_cnt - vb, 1);
        check("a5_latency", v_rise - t0, 79);
        check("a5_fe", fe_cnt, 0);
        check("a5_ovf", o_overflow, 0);

        // Back-to-back frames from the table
        base = rx_q.size();
        for (int i = 0; i < 5; i++) send_byte(vecs[i].tx, 1'b1);
        idle(8);
        check("b2b_count", rx_q.size() - base, 5);
        for (int i = 0; i < 5; i++) check($sformatf("b2b_data%0d", i), rx_q[base + i], vecs[i].exp);
        check("b2b_fe", fe_cnt, 0);

        // Framing error with the line held low for 20 bit times
        base = rx_q.size();
        fb   = fe_cnt;
        t0   = cyc;
        send_byte(8'h3C, 1'b0);
        idle(20 * CPB);
        check("fe_pulses", fe_cnt - fb, 1);
        check("fe_timing", fe_at - t0, 79);
        check("fe_no_push", rx_q.size() - base, 0);
        check("fe_valid", o_valid, 0);
        i_serial = 1'b1;
        idle(2 * CPB);
        send_byte(8'h81, 1'b1);
        idle(8);
        check("fe_next_count", rx_q.size() - base, 1);
        check("fe_next_data", rx_q[base], 8'h81);
        check("fe_next_pulses", fe_cnt - fb, 1);

        // False start: 2-cycle low glitch
        base = rx_q.size();
        i_serial = 1'b0;
        idle(2);
        i_serial = 1'b1;
        idle(2 * CPB);
        check("fs_no_push", rx_q.size() - base, 0);
        send_byte(8'h12, 1'b1);
        idle(8);
        check("fs_next_count", rx_q.size() - base, 1);
        check("fs_next_data", rx_q[base], 8'h12);

        // Overflow, then a pop coinciding with a push into a full FIFO
        base    = rx_q.size();
        i_ready = 1'b0;
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
        idle(4);
        check("ovf_valid", o_valid, 1);
        check("ovf_head", o_data, 8'h01);
        check("ovf_flag", o_overflow, 1);
        check("ovf_no_accept", rx_q.size() - base, 0);
        fork
            send_byte(8'h06, 1'b1);
            begin
                repeat (78) @(posedge i_clk);
                #1 i_ready = 1'b1;
            end
        join
        idle(16);
        check("drain_count", rx_q.size() - base, 5);
        for (int i = 0; i < 5; i++) check($sformatf("drain%0d", i), rx_q[base + i], exp_drain[i]);
        check("drain_empty", o_valid, 0);

        // Reset asserted during data bit 4 of 0x77
        base = rx_q.size();
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (44) @(posedge i_clk);
                #1 i_rst_n = 1'b0;
                #1;
                check("mid_rst_valid", o_valid, 0);
                check("mid_rst_data", o_data, 0);
                check("mid_rst_fe", o_frameErr, 0);
                check("mid_rst_ovf", o_overflow, 0);
            end
        join
        idle(2);
        i_rst_n = 1'b1;
        idle(CPB);
        send_byte(8'h99, 1'b1);
        idle(8);
        check("post_rst_count", rx_q.size() - base, 1);
        check("post_rst_data", rx_q[base], 8'h99);
        check("post_rst_ovf", o_overflow, 0);
        check("post_rst_valid", o_valid, 0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
